// File: rtl/conv2x2_pkg.sv
// Shared types and size helpers for the 2x2 convolution stream engine.
// Optional output register stage is selected with CONV2X2_OUTREG_EN.
package conv2x2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CONV = 2'd2
    } state_e;

    // Bits needed to index v values; never less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned load_beats(input int unsigned img, input int unsigned kn);
        return (img > kn) ? img : kn;
    endfunction

    function automatic int unsigned npos(input int unsigned img);
        return (img - 1) * (img - 1);
    endfunction

    function automatic int unsigned total_results(input int unsigned img, input int unsigned kn);
        return kn * npos(img);
    endfunction

endpackage

// File: rtl/conv2x2_stream_engine_if.sv
// Load-side and result-side handshake bundle of conv2x2_stream_engine.
interface conv2x2_stream_engine_if #(
    parameter int unsigned IMG_SIZE = 6,
    parameter int unsigned PIX_W    = 3,
    parameter int unsigned OUT_W    = 2*PIX_W+2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [IMG_SIZE*PIX_W-1:0] in_row;
    logic [4*PIX_W-1:0]        in_kernel;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_W-1:0]          out_data;
    logic                      busy;
    logic                      frame_done;

    modport slave (
        input  in_valid, in_row, in_kernel, out_ready,
        output in_ready, out_valid, out_data, busy, frame_done
    );

    modport master (
        output in_valid, in_row, in_kernel, out_ready,
        input  in_ready, out_valid, out_data, busy, frame_done
    );
endinterface

// File: rtl/conv2x2_mac.sv
// Combinational four-product adder tree for one 2x2 window.
module conv2x2_mac #(
    parameter int unsigned PIX_W = 3,
    parameter int unsigned OUT_W = 2*PIX_W+2
) (
    input  logic [PIX_W-1:0] i_p00,
    input  logic [PIX_W-1:0] i_p01,
    input  logic [PIX_W-1:0] i_p10,
    input  logic [PIX_W-1:0] i_p11,
    input  logic [PIX_W-1:0] i_w00,
    input  logic [PIX_W-1:0] i_w01,
    input  logic [PIX_W-1:0] i_w10,
    input  logic [PIX_W-1:0] i_w11,
    output logic [OUT_W-1:0] o_sum
);
    localparam int unsigned PW = 2*PIX_W;

    logic [PW-1:0] w_m0, w_m1, w_m2, w_m3;

    assign w_m0  = PW'(i_p00) * PW'(i_w00);
    assign w_m1  = PW'(i_p01) * PW'(i_w01);
    assign w_m2  = PW'(i_p10) * PW'(i_w10);
    assign w_m3  = PW'(i_p11) * PW'(i_w11);
    // OUT_W >= 2*PIX_W+2 leaves room for the carry of four products.
    assign o_sum = OUT_W'(w_m0) + OUT_W'(w_m1) + OUT_W'(w_m2) + OUT_W'(w_m3);
endmodule

// File: rtl/conv2x2_stream_engine.sv
// Loads one ifmap plus KERNEL_NUM 2x2 kernels, then streams all results kernel-major.
// Define CONV2X2_OUTREG_EN to put a flop stage in front of out_valid/out_data.
module conv2x2_stream_engine
    import conv2x2_pkg::*;
#(
    parameter int unsigned IMG_SIZE   = 6,
    parameter int unsigned KERNEL_NUM = 6,
    parameter int unsigned PIX_W      = 3,
    parameter int unsigned OUT_W      = 2*PIX_W+2
) (
    input  logic                    clk,
    input  logic                    rst,
    conv2x2_stream_engine_if.slave  bus
);
    localparam int unsigned LOAD_BEATS = load_beats(IMG_SIZE, KERNEL_NUM);
    localparam int unsigned BW         = clog2(LOAD_BEATS);
    localparam int unsigned IW         = clog2(IMG_SIZE);
    localparam int unsigned KW         = clog2(KERNEL_NUM);

    state_e           r_state;
    logic [BW-1:0]    r_beat;
    logic [IW-1:0]    r_x, r_y;
    logic [KW-1:0]    r_k;
    logic             r_frame_done;
    logic [PIX_W-1:0] r_pix [IMG_SIZE][IMG_SIZE];
    logic [PIX_W-1:0] r_ker [KERNEL_NUM][4];

    logic             w_in_fire;
    logic [BW-1:0]    w_beat;
    logic             w_x_last, w_y_last, w_k_last, w_src_last;
    logic             w_src_valid, w_src_take, w_fin;
    logic [IW-1:0]    w_x1, w_y1;
    logic [OUT_W-1:0] w_sum;

    assign w_in_fire  = bus.in_valid & (r_state != CONV);
    assign w_beat     = (r_state == IDLE) ? '0 : r_beat;
    assign w_x_last   = (r_x == IW'(IMG_SIZE-2));
    assign w_y_last   = (r_y == IW'(IMG_SIZE-2));
    assign w_k_last   = (r_k == KW'(KERNEL_NUM-1));
    assign w_src_last = w_x_last & w_y_last & w_k_last;
    assign w_x1       = r_x + IW'(1);
    assign w_y1       = r_y + IW'(1);

    assign bus.in_ready   = (r_state != CONV);
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = r_frame_done;

    // Storage is never reset; every location is rewritten during LOAD.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            for (int r = 0; r < int'(IMG_SIZE); r++) begin
                if (w_beat == BW'(r)) begin
                    for (int c = 0; c < int'(IMG_SIZE); c++) begin
                        r_pix[r][c] <= bus.in_row[c*PIX_W +: PIX_W];
                    end
                end
            end
            for (int k = 0; k < int'(KERNEL_NUM); k++) begin
                if (w_beat == BW'(k)) begin
                    for (int j = 0; j < 4; j++) begin
                        r_ker[k][j] <= bus.in_kernel[j*PIX_W +: PIX_W];
                    end
                end
            end
        end
    end

    conv2x2_mac #(.PIX_W(PIX_W), .OUT_W(OUT_W)) u_mac (
        .i_p00 (r_pix[r_y][r_x]),
        .i_p01 (r_pix[r_y][w_x1]),
        .i_p10 (r_pix[w_y1][r_x]),
        .i_p11 (r_pix[w_y1][w_x1]),
        .i_w00 (r_ker[r_k][0]),
        .i_w01 (r_ker[r_k][1]),
        .i_w10 (r_ker[r_k][2]),
        .i_w11 (r_ker[r_k][3]),
        .o_sum (w_sum)
    );

`ifdef CONV2X2_OUTREG_EN
    logic             r_src_done;
    logic             r_ov, r_olast;
    logic [OUT_W-1:0] r_od;
    logic             w_stage_open;

    // Stage refills whenever it is empty or its current result is being taken.
    assign w_stage_open = ~r_ov | bus.out_ready;
    assign w_src_valid  = (r_state == CONV) & ~r_src_done;
    assign w_src_take   = w_src_valid & w_stage_open;
    assign w_fin        = r_ov & bus.out_ready & r_olast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ov    <= 1'b0;
            r_od    <= '0;
            r_olast <= 1'b0;
        end else if (w_stage_open) begin
            r_ov    <= w_src_valid;
            r_od    <= w_src_valid ? w_sum : '0;
            r_olast <= w_src_valid & w_src_last;
        end
    end

    assign bus.out_valid = r_ov;
    assign bus.out_data  = r_od;
`else
    assign w_src_valid   = (r_state == CONV);
    assign w_src_take    = w_src_valid & bus.out_ready;
    assign w_fin         = w_src_take & w_src_last;
    assign bus.out_valid = w_src_valid;
    assign bus.out_data  = w_src_valid ? w_sum : '0;
`endif

    // Frame sequencer: beat counter in LOAD, x/y/k walk in CONV.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_k          <= '0;
            r_frame_done <= 1'b0;
`ifdef CONV2X2_OUTREG_EN
            r_src_done   <= 1'b0;
`endif
        end else begin
            r_frame_done <= w_fin;
            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        r_beat  <= (LOAD_BEATS == 1) ? '0 : BW'(1);
                        r_state <= (LOAD_BEATS == 1) ? CONV : LOAD;
                    end
                end
                LOAD: begin
                    if (w_in_fire) begin
                        if (r_beat == BW'(LOAD_BEATS-1)) begin
                            r_beat  <= '0;
                            r_state <= CONV;
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                CONV: begin
                    if (w_src_take) begin
                        if (w_src_last) begin
                            r_x <= '0;
                            r_y <= '0;
                            r_k <= '0;
`ifdef CONV2X2_OUTREG_EN
                            r_src_done <= 1'b1;
`endif
                        end else if (w_x_last) begin
                            r_x <= '0;
                            if (w_y_last) begin
                                r_y <= '0;
                                r_k <= r_k + KW'(1);
                            end else begin
                                r_y <= w_y1;
                            end
                        end else begin
                            r_x <= w_x1;
                        end
                    end
                    if (w_fin) begin
                        r_state <= IDLE;
`ifdef CONV2X2_OUTREG_EN
                        r_src_done <= 1'b0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
